// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared widths, memory request/response codes and RV32 load/store funct3
//   encodings for the load/store unit and its helpers. The helper functions
//   hold the decode rules for access size, illegal encodings and local
//   alignment. Both the unit and its sub-module use these functions, so there
//   is a single source for each rule.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  // Datapath widths
  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  // Request size encodings driven on o_req_count
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  // Response codes returned by memory on i_res_code
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_IDLE       = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

  // RV32 load/store funct3 encodings
  localparam logic [2:0] LSU_F3_LB  = 3'd0;
  localparam logic [2:0] LSU_F3_LH  = 3'd1;
  localparam logic [2:0] LSU_F3_LW  = 3'd2;
  localparam logic [2:0] LSU_F3_LBU = 3'd4;
  localparam logic [2:0] LSU_F3_LHU = 3'd5;
  localparam logic [2:0] LSU_F3_SB  = 3'd0;
  localparam logic [2:0] LSU_F3_SH  = 3'd1;
  localparam logic [2:0] LSU_F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  // Access size from funct3[1:0]. The value 3 is illegal and maps to NONE.
  function automatic logic [MEM_COUNT_W-1:0] lsu_count(input logic [2:0] funct3);
    logic [MEM_COUNT_W-1:0] count;
    case (funct3[1:0])
      2'd0:    count = MEM_COUNT_BYTE;
      2'd1:    count = MEM_COUNT_HALF;
      2'd2:    count = MEM_COUNT_WORD;
      default: count = MEM_COUNT_NONE;
    endcase
    return count;
  endfunction

  // Reserved size, unsigned stores, and the unsigned-word load (funct3 = 6).
  function automatic logic lsu_illegal(input logic is_store, input logic [2:0] funct3);
    return (funct3[1:0] == 2'b11) ||
           (is_store && funct3[2]) ||
           (!is_store && (funct3 == 3'b110));
  endfunction

  // Natural alignment check for the access size.
  function automatic logic lsu_misaligned(input logic [MEM_COUNT_W-1:0] count,
                                          input logic [1:0]             addr_lo);
    return ((count == MEM_COUNT_HALF) && (addr_lo[0] != 1'b0)) ||
           ((count == MEM_COUNT_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational size and sign extension of right-justified load data. Bits
//   above the access size in raw_data are ignored. LB and LH replicate bit 7
//   or bit 15. LBU and LHU fill with zeros. LW passes the word through. The
//   writeback mux can reuse this block on its own.
//   Ports:
//     funct3    in   3        load funct3 (size in [1:0], unsigned in [2])
//     raw_data  in   WORD_W   data from memory, right-justified
//     ext_data  out  WORD_W   extended result
// ---------------------------------------------------------------------------
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] raw_data,
  output logic [WORD_W-1:0] ext_data
);

  logic is_byte;
  logic is_half;
  logic fill_bit;

  assign is_byte  = (funct3[1:0] == 2'd0);
  assign is_half  = (funct3[1:0] == 2'd1);
  // The sign bit of the accessed size. Unsigned forms always fill with zero.
  assign fill_bit = ~funct3[2] & (is_byte ? raw_data[7] : raw_data[15]);

  // Build the result per bit. The low byte always passes. Bits 8..15 are
  // filled only for byte accesses. Bits above 15 are filled for any sub-word
  // access. The reserved size 3 never reaches here with a meaningful op, so
  // it is treated as a word.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_bit
      if (gi < 8) begin : g_low
        assign ext_data[gi] = raw_data[gi];
      end else if (gi < 16) begin : g_mid
        assign ext_data[gi] = is_byte ? fill_bit : raw_data[gi];
      end else begin : g_high
        assign ext_data[gi] = (is_byte || is_half) ? fill_bit : raw_data[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the memory request/response interface. The unit accepts
//   one load or store at a time from execute and checks the encoding and the
//   alignment. It then drives a registered memory request for a fixed number
//   of cycles and samples the response on the last request edge. The result
//   (extended load data or an exception) goes to writeback as a one-cycle
//   o_done pulse. Every output is registered except o_ready.
//   Parameters:
//     RD_LAT  cycles a load request is held before the response is sampled
//     WR_LAT  cycles a store request is held before the response is sampled
//   Ports:
//     clk, areset                 clock, asynchronous active-high reset
//     i_valid / o_ready           op handshake (accept when both high)
//     i_is_store, i_funct3        op kind and width/sign encoding
//     i_addr, i_wr_data           byte address, right-justified store data
//     o_done                      one-cycle completion pulse
//     o_rd_data                   extended load data (0 for stores/exceptions)
//     o_exc_misaligned            misaligned access (with o_done)
//     o_exc_illegal               illegal funct3 (with o_done)
//     o_req_addr/wr_data/count    memory request
//     o_req_wr_en                 memory write enable
//     i_res_rd_data, i_res_code   memory response
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
)
(
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_is_store,
  input  logic [2:0]             i_funct3,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  output logic                   o_done,
  output logic [WORD_W-1:0]      o_rd_data,
  output logic                   o_exc_misaligned,
  output logic                   o_exc_illegal,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  output logic                   o_req_wr_en,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  // The counter only has to hold MAX_LAT-1.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LAT - 1);

  lsu_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   op_store_reg, op_store_next;
  logic [2:0]             op_f3_reg, op_f3_next;
  logic                   done_reg, done_next;
  logic [WORD_W-1:0]      rd_data_reg, rd_data_next;
  logic                   exc_mis_reg, exc_mis_next;
  logic                   exc_ill_reg, exc_ill_next;
  logic [ADDR_W-1:0]      req_addr_reg, req_addr_next;
  logic [WORD_W-1:0]      req_wr_data_reg, req_wr_data_next;
  logic [MEM_COUNT_W-1:0] req_count_reg, req_count_next;
  logic                   req_wr_en_reg, req_wr_en_next;

  logic [MEM_COUNT_W-1:0] in_count;
  logic                   in_illegal;
  logic                   in_misaligned;
  logic [WORD_W-1:0]      ext_data;
  logic                   code_ok;

  assign in_count      = lsu_count(i_funct3);
  assign in_illegal    = lsu_illegal(i_is_store, i_funct3);
  assign in_misaligned = lsu_misaligned(in_count, i_addr[1:0]);

  // The response is usable only if memory answered in the direction of the
  // op. An unexpected code, MISALIGNED included, is reported as misaligned.
  assign code_ok = op_store_reg ? (i_res_code == MEM_CODE_WRITE)
                                : (i_res_code == MEM_CODE_READ);

  load_extend u_load_extend (
    .funct3   (op_f3_reg),
    .raw_data (i_res_rd_data),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg       <= LSU_IDLE;
      cnt_reg         <= '0;
      op_store_reg    <= 1'b0;
      op_f3_reg       <= '0;
      done_reg        <= 1'b0;
      rd_data_reg     <= '0;
      exc_mis_reg     <= 1'b0;
      exc_ill_reg     <= 1'b0;
      req_addr_reg    <= '0;
      req_wr_data_reg <= '0;
      req_count_reg   <= MEM_COUNT_NONE;
      req_wr_en_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      op_store_reg    <= op_store_next;
      op_f3_reg       <= op_f3_next;
      done_reg        <= done_next;
      rd_data_reg     <= rd_data_next;
      exc_mis_reg     <= exc_mis_next;
      exc_ill_reg     <= exc_ill_next;
      req_addr_reg    <= req_addr_next;
      req_wr_data_reg <= req_wr_data_next;
      req_count_reg   <= req_count_next;
      req_wr_en_reg   <= req_wr_en_next;
    end
  end

  always_comb begin
    // Hold the request and op context by default. The result fields drop back
    // to zero unless this edge produces o_done.
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    op_store_next    = op_store_reg;
    op_f3_next       = op_f3_reg;
    done_next        = 1'b0;
    rd_data_next     = '0;
    exc_mis_next     = 1'b0;
    exc_ill_next     = 1'b0;
    req_addr_next    = req_addr_reg;
    req_wr_data_next = req_wr_data_reg;
    req_count_next   = req_count_reg;
    req_wr_en_next   = req_wr_en_reg;

    case (state_reg)
      LSU_IDLE: begin
        if (i_valid) begin
          op_store_next = i_is_store;
          op_f3_next    = i_funct3;
          if (in_illegal) begin
            // Illegal wins over misaligned. No request is issued.
            state_next   = LSU_RESP;
            done_next    = 1'b1;
            exc_ill_next = 1'b1;
          end else if (in_misaligned) begin
            state_next   = LSU_RESP;
            done_next    = 1'b1;
            exc_mis_next = 1'b1;
          end else begin
            state_next       = LSU_REQ;
            req_addr_next    = i_addr;
            req_wr_data_next = i_wr_data;
            req_count_next   = in_count;
            req_wr_en_next   = i_is_store;
            cnt_next         = i_is_store ? WR_CNT_INIT : RD_CNT_INIT;
          end
        end
      end

      LSU_REQ: begin
        if (cnt_reg == '0) begin
          // This edge ends the last request cycle, so the response is sampled
          // here and the request is withdrawn at the same time.
          state_next     = LSU_RESP;
          done_next      = 1'b1;
          req_count_next = MEM_COUNT_NONE;
          req_wr_en_next = 1'b0;
          if (!code_ok) begin
            exc_mis_next = 1'b1;
          end else if (!op_store_reg) begin
            rd_data_next = ext_data;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      LSU_RESP: begin
        state_next = LSU_IDLE;
      end

      default: begin
        state_next = LSU_IDLE;
      end
    endcase
  end

  assign o_ready          = (state_reg == LSU_IDLE);
  assign o_done           = done_reg;
  assign o_rd_data        = rd_data_reg;
  assign o_exc_misaligned = exc_mis_reg;
  assign o_exc_illegal    = exc_ill_reg;
  assign o_req_addr       = req_addr_reg;
  assign o_req_wr_data    = req_wr_data_reg;
  assign o_req_count      = req_count_reg;
  assign o_req_wr_en      = req_wr_en_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with a byte-addressed memory model.
//   Each op pushes its expected completion (data, flags, latency) into a
//   scoreboard queue. The entry is popped and compared when o_done appears.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TB_RD_LAT = 2;
  localparam int TB_WR_LAT = 1;

  logic                   clk = 1'b0;
  logic                   areset;
  logic                   i_valid;
  logic                   o_ready;
  logic                   i_is_store;
  logic [2:0]             i_funct3;
  logic [ADDR_W-1:0]      i_addr;
  logic [WORD_W-1:0]      i_wr_data;
  logic                   o_done;
  logic [WORD_W-1:0]      o_rd_data;
  logic                   o_exc_misaligned;
  logic                   o_exc_illegal;
  logic [ADDR_W-1:0]      o_req_addr;
  logic [WORD_W-1:0]      o_req_wr_data;
  logic [MEM_COUNT_W-1:0] o_req_count;
  logic                   o_req_wr_en;
  logic [WORD_W-1:0]      i_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_res_code;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LAT(TB_RD_LAT), .WR_LAT(TB_WR_LAT)) dut (
    .clk              (clk),
    .areset           (areset),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_is_store       (i_is_store),
    .i_funct3         (i_funct3),
    .i_addr           (i_addr),
    .i_wr_data        (i_wr_data),
    .o_done           (o_done),
    .o_rd_data        (o_rd_data),
    .o_exc_misaligned (o_exc_misaligned),
    .o_exc_illegal    (o_exc_illegal),
    .o_req_addr       (o_req_addr),
    .o_req_wr_data    (o_req_wr_data),
    .o_req_count      (o_req_count),
    .o_req_wr_en      (o_req_wr_en),
    .i_res_rd_data    (i_res_rd_data),
    .i_res_code       (i_res_code)
  );

  // Memory model: 256 bytes. The read returns the full word at the address,
  // so bytes above the access size carry whatever memory holds.
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  logic       force_mis;

  assign ra = o_req_addr[7:0];

  always_comb begin
    i_res_code    = MEM_CODE_IDLE;
    i_res_rd_data = '0;
    if (o_req_count != MEM_COUNT_NONE) begin
      i_res_rd_data = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)],
                       mem[8'(ra + 8'd1)], mem[ra]};
      if (force_mis)        i_res_code = MEM_CODE_MISALIGNED;
      else if (o_req_wr_en) i_res_code = MEM_CODE_WRITE;
      else                  i_res_code = MEM_CODE_READ;
    end
  end

  always @(posedge clk) begin
    if (o_req_wr_en && (o_req_count != MEM_COUNT_NONE)) begin
      for (int b = 0; b < 4; b++) begin
        if ((b == 0) ||
            (b == 1 && o_req_count != MEM_COUNT_BYTE) ||
            (b >= 2 && o_req_count == MEM_COUNT_WORD))
          mem[8'(ra + 8'(b))] <= o_req_wr_data[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one op, push its expectation, then follow it to completion. The
  // request is checked on every cycle before o_done.
  task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic exp_mis,
                       input logic exp_ill);
    exp_t                   e;
    exp_t                   got;
    int                     k;
    logic                   local_exc;
    logic                   done_seen;
    logic [MEM_COUNT_W-1:0] exp_cnt;

    local_exc = exp_ill || (exp_mis && !force_mis);
    e.rd  = exp_rd;
    e.mis = exp_mis;
    e.ill = exp_ill;
    e.lat = local_exc ? 1 : (st ? TB_WR_LAT + 1 : TB_RD_LAT + 1);
    case (f3[1:0])
      2'd0:    exp_cnt = MEM_COUNT_BYTE;
      2'd1:    exp_cnt = MEM_COUNT_HALF;
      default: exp_cnt = MEM_COUNT_WORD;
    endcase
    if (local_exc) exp_cnt = MEM_COUNT_NONE;

    @(negedge clk);
    k = 0;
    while (!o_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, 32'(o_ready), 32'd1);

    i_valid    = 1'b1;
    i_is_store = st;
    i_funct3   = f3;
    i_addr     = addr;
    i_wr_data  = data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble the inputs so that only the value captured at accept counts.
    i_valid    = 1'b0;
    i_is_store = ~st;
    i_funct3   = 3'd3;
    i_addr     = 32'hffff_ffff;
    i_wr_data  = 32'h1234_5678;

    done_seen = 1'b0;
    k = 0;
    while (!done_seen && k < 20) begin
      @(negedge clk);
      k++;
      if (o_done) begin
        done_seen = 1'b1;
        check({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          got = sb_q.pop_front();
          check({tag, " latency"}, 32'(k), 32'(got.lat));
          check({tag, " rd_data"}, o_rd_data, got.rd);
          check({tag, " exc_mis"}, 32'(o_exc_misaligned), 32'(got.mis));
          check({tag, " exc_ill"}, 32'(o_exc_illegal), 32'(got.ill));
        end
        check({tag, " done_count"}, 32'(o_req_count), 32'(MEM_COUNT_NONE));
        check({tag, " done_wr_en"}, 32'(o_req_wr_en), 32'd0);
        check({tag, " done_ready"}, 32'(o_ready), 32'd0);
      end else begin
        check({tag, " req_count"}, 32'(o_req_count), 32'(exp_cnt));
        check({tag, " req_wr_en"}, 32'(o_req_wr_en), 32'(st));
        check({tag, " req_addr"}, o_req_addr, addr);
      end
    end
    if (!done_seen) check({tag, " done_timeout"}, 32'(o_done), 32'd1);

    @(negedge clk);
    check({tag, " post_done"}, 32'(o_done), 32'd0);
    check({tag, " post_rd"}, o_rd_data, 32'd0);
    check({tag, " post_exc"}, 32'({o_exc_misaligned, o_exc_illegal}), 32'd0);
    check({tag, " post_ready"}, 32'(o_ready), 32'd1);
    $display("op %s st=%0d f3=%0d addr=%h -> rd=%h mis=%0d ill=%0d lat=%0d",
             tag, st, f3, addr, exp_rd, exp_mis, exp_ill, e.lat);
  endtask

  initial begin
    areset     = 1'b1;
    i_valid    = 1'b0;
    i_is_store = 1'b0;
    i_funct3   = '0;
    i_addr     = '0;
    i_wr_data  = '0;
    force_mis  = 1'b0;

    #12;
    check("rst ready", 32'(o_ready), 32'd1);
    check("rst done", 32'(o_done), 32'd0);
    check("rst rd", o_rd_data, 32'd0);
    check("rst exc", 32'({o_exc_misaligned, o_exc_illegal}), 32'd0);
    check("rst req_addr", o_req_addr, 32'd0);
    check("rst req_wdata", o_req_wr_data, 32'd0);
    check("rst req_count", 32'(o_req_count), 32'(MEM_COUNT_NONE));
    check("rst req_wr_en", 32'(o_req_wr_en), 32'd0);
    @(negedge clk);
    areset = 1'b0;

    // Word store then load back
    do_op("SW_10", 1'b1, LSU_F3_SW, 32'h10, 32'hdead_beef, 32'h0, 1'b0, 1'b0);
    do_op("LW_10", 1'b0, LSU_F3_LW, 32'h10, 32'h0, 32'hdead_beef, 1'b0, 1'b0);

    // Byte/half extension with non-zero neighbouring bytes
    do_op("SW_20", 1'b1, LSU_F3_SW, 32'h20, 32'h7f7f_7f7f, 32'h0, 1'b0, 1'b0);
    do_op("SB_21", 1'b1, LSU_F3_SB, 32'h21, 32'haaaa_aa80, 32'h0, 1'b0, 1'b0);
    do_op("LB_21", 1'b0, LSU_F3_LB, 32'h21, 32'h0, 32'hffff_ff80, 1'b0, 1'b0);
    do_op("LBU_21", 1'b0, LSU_F3_LBU, 32'h21, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    do_op("LH_20", 1'b0, LSU_F3_LH, 32'h20, 32'h0, 32'hffff_807f, 1'b0, 1'b0);
    do_op("LHU_20", 1'b0, LSU_F3_LHU, 32'h20, 32'h0, 32'h0000_807f, 1'b0, 1'b0);
    do_op("LH_22", 1'b0, LSU_F3_LH, 32'h22, 32'h0, 32'h0000_7f7f, 1'b0, 1'b0);

    // Local misalignment: no request, done one cycle after accept
    do_op("LH_13_mis", 1'b0, LSU_F3_LH, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
    do_op("LW_12_mis", 1'b0, LSU_F3_LW, 32'h12, 32'h0, 32'h0, 1'b1, 1'b0);
    do_op("SH_11_mis", 1'b1, LSU_F3_SH, 32'h11, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
    do_op("LHU_21_mis", 1'b0, LSU_F3_LHU, 32'h21, 32'h0, 32'h0, 1'b1, 1'b0);
    do_op("SW_22_mis", 1'b1, LSU_F3_SW, 32'h22, 32'h5555_5555, 32'h0, 1'b1, 1'b0);

    // Illegal encodings, which win over misalignment
    do_op("L_f3_3_ill", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
    do_op("S_f3_4_ill", 1'b1, 3'd4, 32'h21, 32'h5555_5555, 32'h0, 1'b0, 1'b1);
    do_op("L_f3_6_ill", 1'b0, 3'd6, 32'h13, 32'h0, 32'h0, 1'b0, 1'b1);
    do_op("S_f3_7_ill", 1'b1, 3'd7, 32'h10, 32'h5555_5555, 32'h0, 1'b0, 1'b1);

    // Stored word must be intact after the rejected stores
    do_op("LW_10_again", 1'b0, LSU_F3_LW, 32'h10, 32'h0, 32'hdead_beef, 1'b0, 1'b0);

    // Memory reports MISALIGNED on an aligned load
    force_mis = 1'b1;
    do_op("LW_10_memmis", 1'b0, LSU_F3_LW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    force_mis = 1'b0;

    // Asynchronous reset in the middle of a load request
    @(negedge clk);
    i_valid    = 1'b1;
    i_is_store = 1'b0;
    i_funct3   = LSU_F3_LW;
    i_addr     = 32'h10;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("arst req_active", 32'(o_req_count), 32'(MEM_COUNT_WORD));
    #2;
    areset = 1'b1;
    #1;
    check("arst req_count", 32'(o_req_count), 32'(MEM_COUNT_NONE));
    check("arst req_addr", o_req_addr, 32'd0);
    check("arst req_wr_en", 32'(o_req_wr_en), 32'd0);
    check("arst ready", 32'(o_ready), 32'd1);
    check("arst done", 32'(o_done), 32'd0);
    $display("op arst_mid_LW -> request dropped");
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("arst no_done", 32'(o_done), 32'd0);
    end
    check("arst sb_empty", 32'(sb_q.size()), 32'd0);
    do_op("LW_10_post_rst", 1'b0, LSU_F3_LW, 32'h10, 32'h0, 32'hdead_beef, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
